// File: rtl/fp_pkg.sv
// Shared fp32 definitions for the float arithmetic unit: field layout, exponent
// constants and the divider's state/special-case encodings.
package fp_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   localparam int unsigned FP_BIAS    = 127;
   localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIVIDE,
      ST_NORM
   } state_e;

   typedef enum logic [1:0] {
      SP_NONE,
      SP_DBZ,
      SP_ZERO
   } special_e;

   // Biased quotient exponent, 10-bit two's complement so under/overflow stay visible
   function automatic logic [9:0] fp_exp_diff(input logic [7:0] exp_a, input logic [7:0] exp_b);
      return {2'b00, exp_a} - {2'b00, exp_b} + 10'(FP_BIAS);
   endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Operand/result bundle of the sequential fp32 divider; the divider is the slave,
// whoever issues operations is the master.
interface fp_div_seq_if;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;
   logic        div_by_zero;

   modport master (
      output start, A, B,
      input  busy, done, result, overflow, underflow, div_by_zero
   );

   modport slave (
      input  start, A, B,
      output busy, done, result, overflow, underflow, div_by_zero
   );
endinterface

// File: rtl/fp_div_norm.sv
// Combinational normalise/round/flag stage of the fp32 divider.
// FPDIV_ROUND_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module fp_div_norm
   import fp_pkg::*;
(
   input  logic        sign_i,
   input  logic [9:0]  exp_i,
   input  logic [25:0] quo_i,
   input  logic        rem_nz_i,
   output logic [31:0] result_o,
   output logic        overflow_o,
   output logic        underflow_o
);

   logic [22:0] mant;
   logic        guard;
   logic        sticky;
   logic [9:0]  exp_n;
   fp32_t       res;
`ifdef FPDIV_ROUND_EN
   logic [23:0] mant_rnd;
`else
   logic        unused_rnd;
   assign unused_rnd = guard | sticky;
`endif

   always_comb begin
      mant        = '0;
      guard       = 1'b0;
      sticky      = 1'b0;
      exp_n       = exp_i;
      res         = '0;
      overflow_o  = 1'b0;
      underflow_o = 1'b0;

      // Quotient lies in (0.5, 2): bit 25 carries weight 2^0
      if (quo_i[25]) begin
         mant   = quo_i[24:2];
         guard  = quo_i[1];
         sticky = quo_i[0] | rem_nz_i;
      end else begin
         mant   = quo_i[23:1];
         guard  = quo_i[0];
         sticky = rem_nz_i;
         exp_n  = exp_i - 10'd1;
      end

`ifdef FPDIV_ROUND_EN
      mant_rnd = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
      if (mant_rnd[23]) begin
         exp_n = exp_n + 10'd1;
      end
      mant = mant_rnd[22:0];
`endif

      if (!exp_n[9] && (exp_n[8:0] >= 9'd255)) begin
         overflow_o = 1'b1;
         res.sign   = sign_i;
         res.exp    = FP_EXP_MAX;
         res.frac   = '0;
      end else if (exp_n[9] || (exp_n == 10'd0)) begin
         underflow_o = 1'b1;
         res.sign    = sign_i;
      end else begin
         res.sign = sign_i;
         res.exp  = exp_n[7:0];
         res.frac = mant;
      end
   end

   assign result_o = res;

endmodule

// File: rtl/fp_div_seq.sv
// Iterative fp32 divider: restoring mantissa division, one quotient bit per clock.
// Rounding mode follows FPDIV_ROUND_EN (see fp_div_norm).
module fp_div_seq
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   fp_div_seq_if.slave bus
);

   state_e      state_q,   state_d;
   special_e    special_q, special_d;
   logic        sign_q,    sign_d;
   logic [9:0]  exp_q,     exp_d;
   logic [25:0] rem_q,     rem_d;
   logic [25:0] dvs_q,     dvs_d;
   logic [25:0] quo_q,     quo_d;
   logic [4:0]  cnt_q,     cnt_d;
   logic [31:0] result_q,  result_d;
   logic        ovf_q,     ovf_d;
   logic        unf_q,     unf_d;
   logic        dbz_q,     dbz_d;
   logic        done_q,    done_d;

   logic [25:0] diff;
   logic [31:0] norm_res;
   logic        norm_ovf;
   logic        norm_unf;

   fp_div_norm u_norm (
      .sign_i      (sign_q),
      .exp_i       (exp_q),
      .quo_i       (quo_q),
      .rem_nz_i    (|rem_q),
      .result_o    (norm_res),
      .overflow_o  (norm_ovf),
      .underflow_o (norm_unf)
   );

   assign diff = rem_q - dvs_q;

   always_comb begin
      state_d   = state_q;
      special_d = special_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sign_d = bus.A[31] ^ bus.B[31];
               exp_d  = fp_exp_diff(bus.A[30:23], bus.B[30:23]);
               rem_d  = {2'b01, bus.A[22:0]};
               dvs_d  = {2'b01, bus.B[22:0]};
               quo_d  = '0;
               cnt_d  = '0;
               ovf_d  = 1'b0;
               unf_d  = 1'b0;
               dbz_d  = 1'b0;
               // Special cases skip the division and resolve in NORM one edge later
               if (bus.B[30:23] == 8'h00) begin
                  special_d = SP_DBZ;
                  state_d   = ST_NORM;
               end else if (bus.A[30:23] == 8'h00) begin
                  special_d = SP_ZERO;
                  state_d   = ST_NORM;
               end else begin
                  special_d = SP_NONE;
                  state_d   = ST_DIVIDE;
               end
            end
         end

         ST_DIVIDE: begin
            quo_d = {quo_q[24:0], ~diff[25]};
            rem_d = (diff[25] ? rem_q : diff) << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd25) begin
               state_d = ST_NORM;
            end
         end

         ST_NORM: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            case (special_q)
               SP_DBZ: begin
                  result_d = {sign_q, FP_EXP_MAX, 23'h0};
                  dbz_d    = 1'b1;
               end
               SP_ZERO: begin
                  result_d = {sign_q, 31'h0};
               end
               default: begin
                  result_d = norm_res;
                  ovf_d    = norm_ovf;
                  unf_d    = norm_unf;
               end
            endcase
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         special_q <= SP_NONE;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         special_q <= special_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         dbz_q     <= dbz_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Iterative IEEE-754 single-precision divider, the inverse operation to the combinational float multiplier in the FloatingPointIEEE754 datapath. It accepts a dividend/divisor pair on a start strobe and runs a restoring mantissa division, one quotient bit per clock. It normalises the quotient and registers the result with overflow, underflow and divide-by-zero flags. It sits beside the multiplier as the second operator of the float arithmetic unit and uses the same flag semantics.

## Interface
- No parameters.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  operand-capture strobe; honoured only when busy=0.
- A  in  32  dividend, IEEE-754 single.
- B  in  32  divisor, IEEE-754 single.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; result and flags valid from this cycle until the next accepted start.
- result  out  32  quotient A/B.
- overflow  out  1  result exponent saturated to infinity.
- underflow  out  1  result flushed to signed zero.
- div_by_zero  out  1  B exponent field is 0.

## Operation
- States: IDLE, DIVIDE, NORM.
- **IDLE, start=1:**
  - Register sign = A[31]^B[31].
  - Register exp = {2'b0,expA} - {2'b0,expB} + 127, 10-bit two's complement.
  - Register remainder = {2'b01,A[22:0]}, 26 bits.
  - Register divisor = {2'b01,B[22:0]}.
  - Clear the quotient and set count=0.
- **Special cases**, checked at capture, in priority order. Go straight to IDLE with done=1 on the next edge.
  - B[30:23]==0: result {sign,8'hFF,23'h0}, div_by_zero=1.
  - A[30:23]==0: result {sign,31'h0}, all flags 0.
- **DIVIDE**, 26 iterations, count 0..25. Each iteration:
  - diff = remainder - divisor.
  - Shift the quotient left by one bit, inserting ~diff[25].
  - remainder = (diff[25] ? remainder : diff) << 1.
  - After count=25 go to NORM. The quotient has weights 2^0..2^-25.
- **NORM:**
  - If q[25]=1: mantissa q[24:2], guard bit q[1].
  - Else: mantissa q[23:1], guard bit q[0], exp decremented by 1.
  - Sticky = OR of q below the guard bit and remainder≠0.
  - Apply rounding per Configuration.
  - If biased exp ≥ 255: overflow=1, result {sign,8'hFF,23'h0}.
  - If biased exp ≤ 0 (bit 9 set, or zero): underflow=1, result {sign,31'h0}.
  - Otherwise: result {sign,exp[7:0],mantissa}.
  - Go to IDLE with done=1.
- Inputs with exponent 255 get no special treatment; they are processed numerically.
- Flags are mutually exclusive. All flags are cleared on accepted start.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=32'h0, overflow=0, underflow=0, div_by_zero=0.
- Start accepted at edge E0.
- Normal latency: iterations at E1..E26, NORM at E27. done is high during the cycle after E27, so latency is 27 clocks.
- Special-case latency: done after E1, 1 clock.
- busy is high from E0 until the edge that raises done. busy is 0 in the done cycle.
- start while busy=1 is ignored. A and B are not re-sampled.
- start in the done cycle is accepted: back-to-back throughput of 27 clocks.
- rst has priority over start at every edge. rst mid-DIVIDE aborts with no done and forces the reset values.

## Configuration
- FPDIV_ROUND_EN defined: round-to-nearest-even.
  - Increment the mantissa when guard & (sticky | mantissa[0]).
  - Mantissa carry-out increments exp before the overflow check.
- FPDIV_ROUND_EN undefined: truncate, matching the multiplier. Guard and sticky are ignored.
- Latency is identical either way.

## Structure
- Shared package fp_pkg holds:
  - the fp32 field typedef (sign/exp/frac);
  - constants FP_BIAS=127, FP_EXP_MAX=8'hFF;
  - the state enum.
- One sub-module, fp_div_norm: combinational normalise, round and flag logic used in NORM, so it can be unit-tested alone.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → result 0x40400000, no flags, done exactly 27 cycles after start, busy high for 27 cycles.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA without FPDIV_ROUND_EN, 0x3EAAAAAB with it.
- 0xBF800000 / 0x00000000 → 0xFF800000, div_by_zero=1, done 1 cycle after start. 0x00000000 / 0x3F800000 → 0x00000000, done 1 cycle after start, no flags.
- 0x7F000000 / 0x3E800000 → 0x7F800000, overflow=1. 0x00800000 / 0x40000000 → 0x00000000, underflow=1.
- Second start pulsed mid-DIVIDE with different operands → ignored, first result delivered. New start in the done cycle → accepted, next done 27 cycles later.
- rst at cycle 10 of a DIVIDE → next cycle busy=0, result=0, no done. A following 6/2 completes correctly.
